// File: rtl/ddr_reg_axi_responder_if.sv
// AXI4 register-bus channel bundle (AW/W/B/AR/R) for the DDR controller
// configuration space.
interface ddr_reg_axi_responder_if #(
  parameter int ADDR_W = 15,
  parameter int ID_W   = 6
);
  logic [ADDR_W-1:0] regAWADDR;
  logic [ID_W-1:0]   regAWID;
  logic [7:0]        regAWLEN;
  logic [2:0]        regAWSIZE;
  logic [1:0]        regAWBURST;
  logic              regAWVALID;
  logic              regAWREADY;
  logic [31:0]       regWDATA;
  logic [3:0]        regWSTRB;
  logic              regWLAST;
  logic              regWVALID;
  logic              regWREADY;
  logic [ID_W-1:0]   regBID;
  logic [1:0]        regBRESP;
  logic              regBVALID;
  logic              regBREADY;
  logic [ADDR_W-1:0] regARADDR;
  logic [ID_W-1:0]   regARID;
  logic [7:0]        regARLEN;
  logic [2:0]        regARSIZE;
  logic [1:0]        regARBURST;
  logic              regARVALID;
  logic              regARREADY;
  logic [31:0]       regRDATA;
  logic [ID_W-1:0]   regRID;
  logic [1:0]        regRRESP;
  logic              regRLAST;
  logic              regRVALID;
  logic              regRREADY;

  modport master (
    output regAWADDR, regAWID, regAWLEN, regAWSIZE, regAWBURST, regAWVALID,
    input  regAWREADY,
    output regWDATA, regWSTRB, regWLAST, regWVALID,
    input  regWREADY,
    input  regBID, regBRESP, regBVALID,
    output regBREADY,
    output regARADDR, regARID, regARLEN, regARSIZE, regARBURST, regARVALID,
    input  regARREADY,
    input  regRDATA, regRID, regRRESP, regRLAST, regRVALID,
    output regRREADY
  );

  modport slave (
    input  regAWADDR, regAWID, regAWLEN, regAWSIZE, regAWBURST, regAWVALID,
    output regAWREADY,
    input  regWDATA, regWSTRB, regWLAST, regWVALID,
    output regWREADY,
    output regBID, regBRESP, regBVALID,
    input  regBREADY,
    input  regARADDR, regARID, regARLEN, regARSIZE, regARBURST, regARVALID,
    output regARREADY,
    output regRDATA, regRID, regRRESP, regRLAST, regRVALID,
    input  regRREADY
  );
endinterface

// File: rtl/ddr_reg_axi_responder.sv
// AXI4 responder backing the DDR controller register space: NUM_REGS x 32-bit
// registers, register 0 a read-only ID word, INCR/FIXED bursts with SLVERR.
//
// state   | meaning
// W_IDLE  | waiting for AW (ready once alive)
// W_DATA  | accepting LEN+1 write beats
// W_RESP  | presenting B until BREADY
// R_IDLE  | waiting for AR (ready once alive)
// R_DATA  | presenting read beats, beat data preloaded
module ddr_reg_axi_responder #(
  parameter int unsigned NUM_REGS = 64,
  parameter int          ADDR_W   = 15,
  parameter int          ID_W     = 6,
  parameter logic [31:0] REG0_ID  = 32'hDD4C_0001
) (
  input logic regACLK,
  input logic regARESETn,
  ddr_reg_axi_responder_if.slave bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] burst);
    return (burst == 2'b01) ? a + ADDR_W'(4) : a;
  endfunction

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || burst[1];
  endfunction

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  logic        alive;
  logic [31:0] regs [NUM_REGS];

  w_state_t          w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_beat;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              aw_ready, w_ready, b_valid;

  r_state_t          r_state, r_next;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_beat;
  logic [1:0]        r_burst;
  logic              r_err;
  logic [31:0]       r_data;
  logic [1:0]        r_resp;
  logic              ar_ready, r_valid;

  always_ff @(posedge regACLK or negedge regARESETn) begin
    if (!regARESETn) alive <= 1'b0;
    else             alive <= 1'b1;
  end

  // ---------------- write side ----------------
  logic [IDX_W-1:0] w_idx;
  logic [SEL_W-1:0] w_sel;
  logic             w_last_beat, wlast_bad, w_fire, aw_fire, w_we;

  always_comb begin
    w_idx       = w_addr[ADDR_W-1:2];
    w_sel       = w_idx[SEL_W-1:0];
    w_last_beat = (w_beat == w_len);
    wlast_bad   = (bus.regWLAST != w_last_beat);
    aw_fire     = aw_ready && bus.regAWVALID;
    w_fire      = w_ready && bus.regWVALID;
    // A beat with a WLAST mismatch is itself treated as bad and not written.
    w_we        = w_fire && !w_err && idx_ok(w_idx) && (w_idx != '0) && !wlast_bad;
  end

  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = alive;
        if (alive && bus.regAWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (bus.regWVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (bus.regBREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge regACLK or negedge regARESETn) begin
    if (!regARESETn) w_state <= W_IDLE;
    else             w_state <= w_next;
  end

  always_ff @(posedge regACLK or negedge regARESETn) begin
    if (!regARESETn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_id    <= bus.regAWID;
      w_addr  <= bus.regAWADDR;
      w_len   <= bus.regAWLEN;
      w_burst <= bus.regAWBURST;
      w_beat  <= '0;
      w_err   <= bad_req(bus.regAWSIZE, bus.regAWBURST);
    end else if (w_fire) begin
      w_beat <= w_beat + 8'd1;
      w_addr <= next_addr(w_addr, w_burst);
      if (!idx_ok(w_idx) || wlast_bad) w_err <= 1'b1;
    end
  end

  always_ff @(posedge regACLK or negedge regARESETn) begin
    if (!regARESETn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.regWSTRB[b]) regs[w_sel][8*b +: 8] <= bus.regWDATA[8*b +: 8];
    end
  end

  // ---------------- read side ----------------
  logic [ADDR_W-1:0] ld_addr;
  logic [IDX_W-1:0]  ld_idx;
  logic              ld_err, ar_fire, r_fire, r_last_beat;
  logic [31:0]       ld_data;
  logic [1:0]        ld_resp;

  // Beat data is computed from the pre-edge register array, so a load that
  // coincides with a write to the same register returns the old value.
  always_comb begin
    r_last_beat = (r_beat == r_len);
    ld_addr = (r_state == R_IDLE) ? bus.regARADDR : next_addr(r_addr, r_burst);
    ld_err  = (r_state == R_IDLE) ? bad_req(bus.regARSIZE, bus.regARBURST) : r_err;
    ld_idx  = ld_addr[ADDR_W-1:2];
    ld_data = '0;
    ld_resp = RESP_SLVERR;
    if (!ld_err && idx_ok(ld_idx)) begin
      ld_resp = RESP_OKAY;
      ld_data = (ld_idx == '0) ? REG0_ID : regs[ld_idx[SEL_W-1:0]];
    end
  end

  always_comb begin
    r_next   = r_state;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready = alive;
        if (alive && bus.regARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (bus.regRREADY && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
    ar_fire = ar_ready && bus.regARVALID;
    r_fire  = r_valid && bus.regRREADY;
  end

  always_ff @(posedge regACLK or negedge regARESETn) begin
    if (!regARESETn) r_state <= R_IDLE;
    else             r_state <= r_next;
  end

  always_ff @(posedge regACLK or negedge regARESETn) begin
    if (!regARESETn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (ar_fire) begin
      r_id    <= bus.regARID;
      r_addr  <= bus.regARADDR;
      r_len   <= bus.regARLEN;
      r_burst <= bus.regARBURST;
      r_err   <= ld_err;
      r_beat  <= '0;
      r_data  <= ld_data;
      r_resp  <= ld_resp;
    end else if (r_fire && !r_last_beat) begin
      r_beat <= r_beat + 8'd1;
      r_addr <= ld_addr;
      r_data <= ld_data;
      r_resp <= ld_resp;
    end
  end

  assign bus.regAWREADY = aw_ready;
  assign bus.regWREADY  = w_ready;
  assign bus.regBVALID  = b_valid;
  assign bus.regBID     = w_id;
  assign bus.regBRESP   = (b_valid && w_err) ? RESP_SLVERR : RESP_OKAY;
  assign bus.regARREADY = ar_ready;
  assign bus.regRVALID  = r_valid;
  assign bus.regRID     = r_id;
  assign bus.regRDATA   = r_data;
  assign bus.regRRESP   = r_resp;
  assign bus.regRLAST   = r_valid && r_last_beat;
endmodule
